// File: rtl/legv8_pkg.sv
// legv8_pkg: shared LEGv8 widths, opcode constants and fetch FSM encoding.
package legv8_pkg;

    localparam int INSTR_W  = 32;
    localparam int OPCODE_W = 11;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 11'b10001011000;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 11'b11001011000;
    localparam logic [OPCODE_W-1:0] OP_AND  = 11'b10001010000;
    localparam logic [OPCODE_W-1:0] OP_ORR  = 11'b10101010000;
    localparam logic [OPCODE_W-1:0] OP_LDUR = 11'b11111000010;
    localparam logic [OPCODE_W-1:0] OP_STUR = 11'b11111000000;

    // Fixed encodings so the state register stays compatible with older dumps.
    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_KILL = 3'd3,
        ST_FULL = 3'd4
    } ifu_state_e;

    // Primary opcode field of an instruction word.
    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[31:21];
    endfunction

endpackage

// File: rtl/ifu_instr_buf.sv
// ifu_instr_buf: shift-register FIFO of {pc, instr}. Entry 0 is always the
// head, so the head fields come straight out of flops. Vacated entries are
// zeroed, so an empty buffer presents all-zero head fields.
module ifu_instr_buf
    import legv8_pkg::*;
#(
    parameter int PC_W  = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [PC_W-1:0]            push_pc,
    input  logic [INSTR_W-1:0]         push_instr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       head_valid,
    output logic [PC_W-1:0]            head_pc,
    output logic [INSTR_W-1:0]         head_instr
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]    pc_r    [DEPTH];
    logic [INSTR_W-1:0] instr_r [DEPTH];
    logic [PC_W-1:0]    shift_pc_s    [DEPTH];
    logic [INSTR_W-1:0] shift_instr_s [DEPTH];
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic [CNT_W-1:0]   wr_idx_s;
    logic               valid_r;
    logic               do_pop_s;
    logic               do_push_s;

    // Qualify push/pop, pick the write slot and compute the shifted-down image.
    always_comb begin
        do_pop_s  = pop && (count_r != '0);
        do_push_s = push && !flush && ((count_r != CNT_W'(DEPTH)) || do_pop_s);
        if (do_pop_s) begin
            wr_idx_s = count_r - CNT_W'(1);
        end else begin
            wr_idx_s = count_r;
        end
        if (flush) begin
            count_nxt_s = '0;
        end else begin
            count_nxt_s = count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            shift_pc_s[i]    = pc_r[i+1];
            shift_instr_s[i] = instr_r[i+1];
        end
        shift_pc_s[DEPTH-1]    = '0;
        shift_instr_s[DEPTH-1] = '0;
    end

    // Storage: flush clears everything (after any pop), otherwise shift and/or write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_r[i]    <= '0;
                instr_r[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_r[i]    <= '0;
                instr_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push_s && (wr_idx_s == CNT_W'(i))) begin
                    pc_r[i]    <= push_pc;
                    instr_r[i] <= push_instr;
                end else if (do_pop_s) begin
                    pc_r[i]    <= shift_pc_s[i];
                    instr_r[i] <= shift_instr_s[i];
                end
            end
        end
    end

    // Occupancy and registered non-empty flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
            valid_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != '0);
        end
    end

    assign count      = count_r;
    assign head_valid = valid_r;
    assign head_pc    = pc_r[0];
    assign head_instr = instr_r[0];

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: LEGv8 fetch front end. Holds the PC, issues one word
// request at a time to instruction memory, buffers responses for decode and
// redirects on a taken branch, dropping wrong-path data.
// Build option: define IFU_PERF_CNT_EN to add perf_fetched / perf_flushed.
module instr_fetch_unit
    import legv8_pkg::*;
#(
    parameter int              PC_W      = 64,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [PC_W-1:0]     imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    output logic                dec_valid,
    input  logic                dec_ready,
    output logic [INSTR_W-1:0]  dec_instr,
    output logic [OPCODE_W-1:0] dec_opcode,
    output logic [PC_W-1:0]     dec_pc,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_target
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_flushed
`endif
);

    localparam int              CNT_W      = $clog2(BUF_DEPTH + 1);
    localparam logic [PC_W-1:0] ALIGN_MASK = {{(PC_W-2){1'b1}}, 2'b00};

    ifu_state_e       state_r, state_nxt_s;
    logic [PC_W-1:0]  pc_r, pc_nxt_s;
    logic [PC_W-1:0]  req_pc_r, req_pc_nxt_s;
    logic             req_valid_r;
    logic             fire_s;
    logic             pop_s;
    logic             push_s;
    logic [CNT_W-1:0] count_s;
    logic [CNT_W-1:0] cnt_after_s;

    assign fire_s      = req_valid_r && imem_req_ready;
    assign pop_s       = dec_valid && dec_ready;
    // A response racing a redirect is wrong-path and never enters the buffer.
    assign push_s      = (state_r == ST_WAIT) && imem_rsp_valid && !redirect;
    assign cnt_after_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);

    // Next state, next PC and the PC tagged onto the outstanding request.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BOOT: state_nxt_s = ST_REQ;
            ST_REQ: begin
                if (fire_s) begin
                    state_nxt_s = redirect ? ST_KILL : ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    state_nxt_s = imem_rsp_valid ? ST_REQ : ST_KILL;
                end else if (imem_rsp_valid) begin
                    state_nxt_s = (cnt_after_s < CNT_W'(BUF_DEPTH)) ? ST_REQ : ST_FULL;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_FULL: begin
                if (redirect || pop_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            ST_KILL: begin
                // The single killed response closes out the old request.
                if (imem_rsp_valid) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_KILL;
                end
            end
            default: state_nxt_s = ST_BOOT;
        endcase

        if (redirect) begin
            pc_nxt_s = redirect_target & ALIGN_MASK;
        end else if (fire_s) begin
            pc_nxt_s = pc_r + PC_W'(4);
        end else begin
            pc_nxt_s = pc_r;
        end

        if (fire_s) begin
            req_pc_nxt_s = pc_r;
        end else begin
            req_pc_nxt_s = req_pc_r;
        end
    end

    // FSM, PC and registered request-valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_BOOT;
            pc_r        <= RESET_PC & ALIGN_MASK;
            req_pc_r    <= '0;
            req_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            req_pc_r    <= req_pc_nxt_s;
            req_valid_r <= (state_nxt_s == ST_REQ);
        end
    end

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = pc_r;

    ifu_instr_buf #(
        .PC_W  (PC_W),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (redirect),
        .push_pc    (req_pc_r),
        .push_instr (imem_rsp_data),
        .count      (count_s),
        .head_valid (dec_valid),
        .head_pc    (dec_pc),
        .head_instr (dec_instr)
    );

    assign dec_opcode = opcode_of(dec_instr);

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_flushed_r;
    logic        kill_new_s;
    logic [31:0] flushed_inc_s;

    // A redirect kills a response only if one is outstanding and not yet killed.
    assign kill_new_s    = (state_r == ST_WAIT) || fire_s;
    assign flushed_inc_s = 32'(count_s) - 32'(pop_s) + 32'(kill_new_s);

    // Fetched / flushed event counters, free-running modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_r <= 32'd0;
            perf_flushed_r <= 32'd0;
        end else begin
            perf_fetched_r <= perf_fetched_r + 32'(push_s);
            if (redirect) begin
                perf_flushed_r <= perf_flushed_r + flushed_inc_s;
            end
        end
    end

    assign perf_fetched = perf_fetched_r;
    assign perf_flushed = perf_flushed_r;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table-driven stream plus hand-written corner sequences,
// with a scoreboard of expected decode entries. A second instance uses an
// 8-bit PC to exercise address wrap.
module tb_instr_fetch_unit;
    import legv8_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;

    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_instr;
    logic [10:0] dec_opcode;
    logic [63:0] dec_pc;
    logic        redirect;
    logic [63:0] redirect_target;

    logic        w_req_valid, w_req_ready;
    logic [7:0]  w_req_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_dec_valid, w_dec_ready;
    logic [31:0] w_dec_instr;
    logic [10:0] w_dec_opcode;
    logic [7:0]  w_dec_pc;
    logic        w_redirect;
    logic [7:0]  w_redirect_target;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed, w_perf_fetched, w_perf_flushed;
`endif

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [10:0] opcode;
    } sb_entry_t;

    typedef struct {
        logic [31:0] data;
        logic [10:0] opcode;
    } vec_t;

    sb_entry_t sb_q[$];
    vec_t      vecs[6];
    int        checks = 0;
    int        errors = 0;
    int        cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_fetch_unit #(.PC_W(64), .RESET_PC(64'h0), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_opcode(dec_opcode), .dec_pc(dec_pc),
        .redirect(redirect), .redirect_target(redirect_target)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );

    instr_fetch_unit #(.PC_W(8), .RESET_PC(8'hFC), .BUF_DEPTH(2)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
        .imem_rsp_data(w_rsp_data), .dec_valid(w_dec_valid), .dec_ready(w_dec_ready),
        .dec_instr(w_dec_instr), .dec_opcode(w_dec_opcode), .dec_pc(w_dec_pc),
        .redirect(w_redirect), .redirect_target(w_redirect_target)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetched(w_perf_fetched), .perf_flushed(w_perf_flushed)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle; a decode handshake about to happen is checked against the scoreboard.
    task automatic tick();
        sb_entry_t e;
        if (dec_valid && dec_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_pop: decode handshake at pc %0h with empty scoreboard", dec_pc);
            end else begin
                e = sb_q.pop_front();
                check("sb_dec_pc", dec_pc, e.pc);
                check("sb_dec_instr", 64'(dec_instr), 64'(e.instr));
                check("sb_dec_opcode", 64'(dec_opcode), 64'(e.opcode));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Serve one request with a 1-cycle memory and record the expected decode entry.
    task automatic fetch_one(input logic [31:0] data, input logic [10:0] opc, input logic [63:0] exp_addr);
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            tick();
            n++;
        end
        check("req_valid", 64'(imem_req_valid), 64'd1);
        check("req_addr", imem_req_addr, exp_addr);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        sb_q.push_back('{pc: exp_addr, instr: data, opcode: opc});
        tick();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic redirect_tick(input logic [63:0] target);
        redirect        = 1'b1;
        redirect_target = target;
        tick();
        redirect = 1'b0;
        sb_q.delete();
    endtask

    task automatic clear_inputs();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        dec_ready = 1'b0; redirect = 1'b0; redirect_target = 64'h0;
        w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = 32'h0;
        w_dec_ready = 1'b0; w_redirect = 1'b0; w_redirect_target = 8'h0;
    endtask

    // Pulse reset; on return both instances have left BOOT and sit in REQ.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        sb_q.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc0;
        vecs[0] = '{data: 32'h8B020020, opcode: OP_ADD};
        vecs[1] = '{data: 32'hCB020020, opcode: OP_SUB};
        vecs[2] = '{data: 32'h8A020020, opcode: OP_AND};
        vecs[3] = '{data: 32'hAA020020, opcode: OP_ORR};
        vecs[4] = '{data: 32'hF8400020, opcode: OP_LDUR};
        vecs[5] = '{data: 32'hF8000020, opcode: OP_STUR};

        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_req_addr", imem_req_addr, 64'h0);
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        check("rst_dec_instr", 64'(dec_instr), 64'd0);
        check("rst_dec_opcode", 64'(dec_opcode), 64'd0);
        check("rst_dec_pc", dec_pc, 64'h0);

        // Boot fetch
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fetch_one(32'h8B020020, OP_ADD, 64'h0);
        check("boot_dec_valid", 64'(dec_valid), 64'd1);
        check("boot_dec_opcode", 64'(dec_opcode), 64'(OP_ADD));
        check("boot_dec_pc", dec_pc, 64'h0);
        check("boot_next_valid", 64'(imem_req_valid), 64'd1);
        check("boot_next_addr", imem_req_addr, 64'h4);

        // Backpressure: two entries fill the buffer
        fetch_one(32'hCB020020, OP_SUB, 64'h4);
        check("full_req_valid", 64'(imem_req_valid), 64'd0);
        tick();
        tick();
        check("full_hold_valid", 64'(imem_req_valid), 64'd0);
        check("full_head_pc", dec_pc, 64'h0);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        check("unfull_req_valid", 64'(imem_req_valid), 64'd1);
        check("unfull_req_addr", imem_req_addr, 64'h8);
        check("unfull_head_pc", dec_pc, 64'h4);

        // Table-driven stream at full rate
        dec_ready = 1'b1;
        cyc0 = cyc;
        for (int i = 0; i < 6; i++) begin
            fetch_one(vecs[i].data, vecs[i].opcode, 64'h8 + 64'(4 * i));
        end
        check("stream_cycles", 64'(cyc - cyc0), 64'd12);
        tick();
        check("stream_drained", 64'(sb_q.size()), 64'd0);
        check("stream_dec_valid", 64'(dec_valid), 64'd0);

        // Redirect while the 0x4 response is outstanding
        do_reset();
        dec_ready = 1'b1;
        fetch_one(32'h8B020020, OP_ADD, 64'h0);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_tick(64'h100);
        check("kill_dec_valid", 64'(dec_valid), 64'd0);
        check("kill_req_valid", 64'(imem_req_valid), 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEADBEEF;
        tick();
        imem_rsp_valid = 1'b0;
        check("kill_drop_valid", 64'(dec_valid), 64'd0);
        check("kill_next_addr", imem_req_addr, 64'h100);
        fetch_one(32'hAA020020, OP_ORR, 64'h100);
        check("kill_first_pc", dec_pc, 64'h100);
        tick();

        // Redirect and response in the same WAIT cycle
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b1;
        imem_rsp_data   = 32'h12345678;
        redirect        = 1'b1;
        redirect_target = 64'h200;
        tick();
        imem_rsp_valid = 1'b0;
        redirect       = 1'b0;
        sb_q.delete();
        check("race_req_valid", 64'(imem_req_valid), 64'd1);
        check("race_req_addr", imem_req_addr, 64'h200);
        tick();
        check("race_dec_valid", 64'(dec_valid), 64'd0);

        // Unaligned redirect while the head is being popped
        dec_ready = 1'b0;
        fetch_one(32'hF8400020, OP_LDUR, 64'h200);
        fetch_one(32'hF8000020, OP_STUR, 64'h204);
        dec_ready = 1'b1;
        redirect_tick(64'h103);
        dec_ready = 1'b0;
        check("unal_dec_valid", 64'(dec_valid), 64'd0);
        check("unal_req_valid", 64'(imem_req_valid), 64'd1);
        check("unal_req_addr", imem_req_addr, 64'h100);

        // Redirect in the cycle a request is accepted
        imem_req_ready  = 1'b1;
        redirect        = 1'b1;
        redirect_target = 64'h300;
        tick();
        imem_req_ready = 1'b0;
        redirect       = 1'b0;
        check("acc_kill_valid", 64'(imem_req_valid), 64'd0);
        imem_rsp_valid = 1'b1;
        tick();
        imem_rsp_valid = 1'b0;
        check("acc_kill_addr", imem_req_addr, 64'h300);
        check("acc_kill_dec", 64'(dec_valid), 64'd0);

        // Asynchronous reset while waiting on memory
        fetch_one(32'h8B020020, OP_ADD, 64'h300);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check("pre_rst_dec_valid", 64'(dec_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_dec_valid", 64'(dec_valid), 64'd0);
        check("arst_req_valid", 64'(imem_req_valid), 64'd0);
        check("arst_req_addr", imem_req_addr, 64'h0);
        sb_q.delete();
        @(negedge clk);
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        check("stale_dec_valid", 64'(dec_valid), 64'd0);
        check("stale_req_addr", imem_req_addr, 64'h0);
        tick();
        check("stale_dec_valid2", 64'(dec_valid), 64'd0);
        dec_ready = 1'b1;
        fetch_one(32'h8B020020, OP_ADD, 64'h0);
        tick();

        // 8-bit PC wrap on the second instance
        do_reset();
        check("w_req_valid", 64'(w_req_valid), 64'd1);
        check("w_addr0", 64'(w_req_addr), 64'hFC);
        w_req_ready = 1'b1;
        tick();
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b1;
        w_rsp_data  = 32'h8B020020;
        tick();
        w_rsp_valid = 1'b0;
        check("w_addr1", 64'(w_req_addr), 64'h00);
        check("w_dec_pc", 64'(w_dec_pc), 64'hFC);
        check("w_dec_opcode", 64'(w_dec_opcode), 64'(OP_ADD));
        w_req_ready = 1'b1;
        tick();
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b1;
        w_rsp_data  = 32'hCB020020;
        tick();
        w_rsp_valid = 1'b0;
        check("w_full", 64'(w_req_valid), 64'd0);
`ifdef IFU_PERF_CNT_EN
        check("w_perf_fetched", 64'(w_perf_fetched), 64'd2);
        check("w_perf_flushed0", 64'(w_perf_flushed), 64'd0);
`endif
        w_redirect        = 1'b1;
        w_redirect_target = 8'h41;
        tick();
        w_redirect = 1'b0;
        check("w_redir_dec", 64'(w_dec_valid), 64'd0);
        check("w_redir_addr", 64'(w_req_addr), 64'h40);
`ifdef IFU_PERF_CNT_EN
        check("w_perf_flushed", 64'(w_perf_flushed), 64'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
